// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and default sizes for the cache/memory arbiter.
// Optional feature macro used by this slice: MEM_ARB_RR_EN (round-robin arbitration).
package mem_arb_pkg;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RD_RESP = 2'd2
   } state_t;

   // Current owner of the memory port, as seen on arb_owner
   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IC   = 2'b01,
      OWN_DC   = 2'b10
   } owner_t;

   localparam int DEF_ADDR_BITS = 28;
   localparam int DEF_DATA_BITS = 128;
   localparam int DEF_MASK_BITS = DEF_DATA_BITS / 8;
   localparam int DEF_BEATS     = 4;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: two-request winner select for the memory arbiter.
// MEM_ARB_RR_EN defined: round-robin, the client that did not win last wins contention;
// the last-winner flag resets to dc so ic wins the first contention.
// MEM_ARB_RR_EN undefined: fixed priority, dc always wins contention.
module arb_pick (
`ifdef MEM_ARB_RR_EN
   input  logic clk,
   input  logic reset_n,
   input  logic upd,
`endif
   input  logic ic_req,
   input  logic dc_req,
   output logic pick_ic,
   output logic pick_dc
);

`ifdef MEM_ARB_RR_EN
   logic last_dc;

   // Remember who won the most recent grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         last_dc <= 1'b1;
      else if (upd && (ic_req || dc_req))
         last_dc <= pick_dc;
   end

   // dc wins if alone, or on contention when ic won last time
   always_comb begin
      pick_dc = dc_req && (!ic_req || !last_dc);
      pick_ic = ic_req && !pick_dc;
   end
`else
   // dc has absolute priority on contention
   always_comb begin
      pick_dc = dc_req;
      pick_ic = ic_req && !dc_req;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction and data caches.
// One client owns the port per transaction; reads own it until the last response beat.
// Optional macro MEM_ARB_RR_EN selects round-robin instead of dc-first fixed priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int MASK_BITS = DEF_MASK_BITS,
   parameter int BEATS     = DEF_BEATS
) (
   input  logic                 clk,
   input  logic                 reset_n,
   // instruction cache side
   input  logic                 ic_req_valid,
   output logic                 ic_req_ready,
   input  logic [ADDR_BITS-1:0] ic_req_addr,
   input  logic                 ic_req_rw,
   input  logic                 ic_data_valid,
   output logic                 ic_data_ready,
   input  logic [DATA_BITS-1:0] ic_data_bits,
   input  logic [MASK_BITS-1:0] ic_data_mask,
   output logic                 ic_resp_valid,
   output logic [DATA_BITS-1:0] ic_resp_data,
   // data cache side
   input  logic                 dc_req_valid,
   output logic                 dc_req_ready,
   input  logic [ADDR_BITS-1:0] dc_req_addr,
   input  logic                 dc_req_rw,
   input  logic                 dc_data_valid,
   output logic                 dc_data_ready,
   input  logic [DATA_BITS-1:0] dc_data_bits,
   input  logic [MASK_BITS-1:0] dc_data_mask,
   output logic                 dc_resp_valid,
   output logic [DATA_BITS-1:0] dc_resp_data,
   // memory side
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic [ADDR_BITS-1:0] mem_req_addr,
   output logic                 mem_req_rw,
   output logic                 mem_req_data_valid,
   input  logic                 mem_req_data_ready,
   output logic [DATA_BITS-1:0] mem_req_data_bits,
   output logic [MASK_BITS-1:0] mem_req_data_mask,
   input  logic                 mem_resp_valid,
   input  logic [DATA_BITS-1:0] mem_resp_data,
   output logic [1:0]           arb_owner
);

   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   state_t        state;
   owner_t        owner;
   logic          cur_rw;
   logic          addr_done;
   logic          data_done;
   logic [CW-1:0] beat_cnt;

   logic pick_ic, pick_dc;
   logic own_ic, own_dc, in_grant, in_rd, in_idle;
   logic addr_phase, wr_phase, addr_fire, data_fire;
   logic                 sel_req_valid, sel_data_valid;
   logic [ADDR_BITS-1:0] sel_addr;
   logic [DATA_BITS-1:0] sel_bits;
   logic [MASK_BITS-1:0] sel_mask;

   arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
      .clk     (clk),
      .reset_n (reset_n),
      .upd     (in_idle),
`endif
      .ic_req  (ic_req_valid),
      .dc_req  (dc_req_valid),
      .pick_ic (pick_ic),
      .pick_dc (pick_dc)
   );

   // Owner mux and memory/client handshake steering
   always_comb begin
      own_ic     = (owner == OWN_IC);
      own_dc     = (owner == OWN_DC);
      in_idle    = (state == ST_IDLE);
      in_grant   = (state == ST_GRANT);
      in_rd      = (state == ST_RD_RESP);

      sel_req_valid  = own_dc ? dc_req_valid  : (own_ic & ic_req_valid);
      sel_data_valid = own_dc ? dc_data_valid : (own_ic & ic_data_valid);
      sel_addr       = own_dc ? dc_req_addr   : ic_req_addr;
      sel_bits       = own_dc ? dc_data_bits  : ic_data_bits;
      sel_mask       = own_dc ? dc_data_mask  : ic_data_mask;

      // Address and write-data sides retire independently during GRANT
      addr_phase = in_grant && !addr_done;
      wr_phase   = in_grant && cur_rw && !data_done;

      mem_req_valid      = addr_phase && sel_req_valid;
      mem_req_addr       = addr_phase ? sel_addr : '0;
      mem_req_rw         = addr_phase && cur_rw;
      mem_req_data_valid = wr_phase && sel_data_valid;
      mem_req_data_bits  = wr_phase ? sel_bits : '0;
      mem_req_data_mask  = wr_phase ? sel_mask : '0;

      addr_fire = mem_req_valid && mem_req_ready;
      data_fire = mem_req_data_valid && mem_req_data_ready;

      ic_req_ready  = addr_phase && own_ic && mem_req_ready;
      dc_req_ready  = addr_phase && own_dc && mem_req_ready;
      ic_data_ready = wr_phase && own_ic && mem_req_data_ready;
      dc_data_ready = wr_phase && own_dc && mem_req_data_ready;

      // Read beats go to the owner only, and only while a read is open
      ic_resp_valid = in_rd && own_ic && mem_resp_valid;
      dc_resp_valid = in_rd && own_dc && mem_resp_valid;
      ic_resp_data  = (in_rd && own_ic) ? mem_resp_data : '0;
      dc_resp_data  = (in_rd && own_dc) ? mem_resp_data : '0;

      arb_owner = owner;
   end

   // Transaction sequencer: grant, address/data retirement, read beat counting
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         owner     <= OWN_NONE;
         cur_rw    <= 1'b0;
         addr_done <= 1'b0;
         data_done <= 1'b0;
         beat_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_ic || pick_dc) begin
                  owner     <= pick_dc ? OWN_DC : OWN_IC;
                  cur_rw    <= pick_dc ? dc_req_rw : ic_req_rw;
                  addr_done <= 1'b0;
                  data_done <= 1'b0;
                  state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!cur_rw) begin
                  if (addr_fire) begin
                     addr_done <= 1'b1;
                     beat_cnt  <= '0;
                     state     <= ST_RD_RESP;
                  end
               end else if ((addr_done || addr_fire) && (data_done || data_fire)) begin
                  addr_done <= 1'b0;
                  data_done <= 1'b0;
                  owner     <= OWN_NONE;
                  state     <= ST_IDLE;
               end else begin
                  if (addr_fire) addr_done <= 1'b1;
                  if (data_fire) data_done <= 1'b1;
               end
            end
            ST_RD_RESP: begin
               if (mem_resp_valid) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt  <= '0;
                     addr_done <= 1'b0;
                     owner     <= OWN_NONE;
                     state     <= ST_IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end
            end
            default: begin
               owner <= OWN_NONE;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for stalls, arbitration
// order and mid-transaction reset.
module tb_mem_arbiter;

   localparam logic [27:0]  IA = 28'h0000123;
   localparam logic [27:0]  DA = 28'h0ABCDEF;
   localparam logic [127:0] DB = 128'hCAFE_0000_1111_2222_3333_4444_5555_BEEF;
   localparam logic [15:0]  DM = 16'hA5C3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic ic_req_valid = 0, ic_req_rw = 0, ic_data_valid = 0;
   logic dc_req_valid = 0, dc_req_rw = 0, dc_data_valid = 0;
   logic [27:0]  ic_req_addr = IA, dc_req_addr = DA;
   logic [127:0] ic_data_bits = 128'h1, dc_data_bits = DB;
   logic [15:0]  ic_data_mask = 16'h1, dc_data_mask = DM;
   logic mem_req_ready = 0, mem_req_data_ready = 0, mem_resp_valid = 0;
   logic [127:0] mem_resp_data = '0;
   logic ic_req_ready, ic_data_ready, ic_resp_valid;
   logic dc_req_ready, dc_data_ready, dc_resp_valid;
   logic [127:0] ic_resp_data, dc_resp_data, mem_req_data_bits;
   logic mem_req_valid, mem_req_rw, mem_req_data_valid;
   logic [27:0] mem_req_addr;
   logic [15:0] mem_req_data_mask;
   logic [1:0]  arb_owner;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
      .ic_req_rw(ic_req_rw), .ic_data_valid(ic_data_valid), .ic_data_ready(ic_data_ready),
      .ic_data_bits(ic_data_bits), .ic_data_mask(ic_data_mask),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
      .dc_req_rw(dc_req_rw), .dc_data_valid(dc_data_valid), .dc_data_ready(dc_data_ready),
      .dc_data_bits(dc_data_bits), .dc_data_mask(dc_data_mask),
      .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
      .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
      .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .arb_owner(arb_owner)
   );

   // in = {ic_v, ic_rw, dc_v, dc_rw, dc_dv, mem_rdy, mem_data_rdy, mem_resp_v}
   // ex = {mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready, mem_data_valid, ic_resp_v, dc_resp_v}
   typedef struct {
      logic [7:0]  in;
      logic [1:0]  own;
      logic [6:0]  ex;
      logic [27:0] addr;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   function automatic vec_t mk(input logic [7:0] in, input logic [1:0] own,
                               input logic [6:0] ex, input logic [27:0] addr);
      vec_t v;
      v.in = in; v.own = own; v.ex = ex; v.addr = addr;
      return v;
   endfunction

   function automatic logic [6:0] obs();
      return {mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready,
              mem_req_data_valid, ic_resp_valid, dc_resp_valid};
   endfunction

   logic [1:0] rr_exp[4];

   initial begin
      // ic read alone, then a stray beat in IDLE
      tbl[0]  = mk(8'b1000_0000, 2'b00, 7'b0000000, 28'h0);
      tbl[1]  = mk(8'b1000_0100, 2'b01, 7'b1010000, IA);
      tbl[2]  = mk(8'b0000_0001, 2'b01, 7'b0000010, 28'h0);
      tbl[3]  = mk(8'b0000_0000, 2'b01, 7'b0000000, 28'h0);
      tbl[4]  = mk(8'b0000_0001, 2'b01, 7'b0000010, 28'h0);
      tbl[5]  = mk(8'b0000_0001, 2'b01, 7'b0000010, 28'h0);
      tbl[6]  = mk(8'b0000_0001, 2'b01, 7'b0000010, 28'h0);
      tbl[7]  = mk(8'b0000_0000, 2'b00, 7'b0000000, 28'h0);
      tbl[8]  = mk(8'b0000_0001, 2'b00, 7'b0000000, 28'h0);
      tbl[9]  = mk(8'b0000_0000, 2'b00, 7'b0000000, 28'h0);
      // ic read vs dc write contention: dc first, ic waits through a full IDLE pass
      tbl[10] = mk(8'b1011_1000, 2'b00, 7'b0000000, 28'h0);
      tbl[11] = mk(8'b1011_1110, 2'b10, 7'b1101100, DA);
      tbl[12] = mk(8'b1000_0000, 2'b00, 7'b0000000, 28'h0);
      tbl[13] = mk(8'b1000_0000, 2'b01, 7'b1000000, IA);
      tbl[14] = mk(8'b1000_0100, 2'b01, 7'b1010000, IA);
      tbl[15] = mk(8'b0000_0001, 2'b01, 7'b0000010, 28'h0);
      tbl[16] = mk(8'b0000_0001, 2'b01, 7'b0000010, 28'h0);
      tbl[17] = mk(8'b0000_0001, 2'b01, 7'b0000010, 28'h0);
      tbl[18] = mk(8'b0000_0001, 2'b01, 7'b0000010, 28'h0);
      tbl[19] = mk(8'b0000_0000, 2'b00, 7'b0000000, 28'h0);

`ifdef MEM_ARB_RR_EN
      rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
`else
      rr_exp[0] = 2'b10; rr_exp[1] = 2'b10; rr_exp[2] = 2'b10; rr_exp[3] = 2'b10;
`endif

      // reset state
      ic_req_valid = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_owner", arb_owner, 2'b00);
      chk("rst_outs", obs(), 7'b0);
      chk("rst_addr", mem_req_addr, 28'h0);
      ic_req_valid = 1'b0;
      reset_n = 1'b1;
      tick();

      // vector table
      for (int i = 0; i < 20; i++) begin
         {ic_req_valid, ic_req_rw, dc_req_valid, dc_req_rw, dc_data_valid,
          mem_req_ready, mem_req_data_ready, mem_resp_valid} = tbl[i].in;
         mem_resp_data = 128'hD0 + 128'(i);
         settle();
         chk($sformatf("vec%0d_owner", i), arb_owner, tbl[i].own);
         chk($sformatf("vec%0d_ctl", i), obs(), tbl[i].ex);
         chk($sformatf("vec%0d_addr", i), mem_req_addr, tbl[i].addr);
         if (tbl[i].ex[1]) chk($sformatf("vec%0d_rdata", i), ic_resp_data, 128'hD0 + 128'(i));
         tick();
      end

      // dc write, data accept stalled 3 cycles after address fires
      dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_data_valid = 1'b1;
      mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
      settle(); tick();
      mem_req_ready = 1'b1;
      settle();
      chk("wr_addr_v", mem_req_valid, 1'b1);
      chk("wr_dc_rdy", dc_req_ready, 1'b1);
      chk("wr_data_v", mem_req_data_valid, 1'b1);
      chk("wr_data_rdy0", dc_data_ready, 1'b0);
      chk("wr_bits", mem_req_data_bits, DB);
      chk("wr_mask", mem_req_data_mask, DM);
      tick();
      dc_req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk($sformatf("wr_stall%0d_addr", c), mem_req_valid, 1'b0);
         chk($sformatf("wr_stall%0d_data", c), mem_req_data_valid, 1'b1);
         chk($sformatf("wr_stall%0d_own", c), arb_owner, 2'b10);
         tick();
      end
      mem_req_data_ready = 1'b1;
      settle();
      chk("wr_data_rdy1", dc_data_ready, 1'b1);
      tick();
      dc_data_valid = 1'b0; mem_req_data_ready = 1'b0; mem_req_ready = 1'b0; dc_req_rw = 1'b0;
      settle();
      chk("wr_done_own", arb_owner, 2'b00);
      chk("wr_done_dv", mem_req_data_valid, 1'b0);
      tick();

      // both clients reading continuously: grant order
      ic_req_valid = 1'b1; dc_req_valid = 1'b1; mem_req_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         int k;
         k = 0;
         settle();
         while (!mem_req_valid && k < 20) begin
            tick(); settle(); k++;
         end
         if (k == 20) begin
            n_total++;
            $display("FAIL arb_wait%0d actual=no grant expected=grant within 20 cycles", g);
         end else begin
            chk($sformatf("arb_order%0d", g), arb_owner, rr_exp[g]);
         end
         tick();
         mem_resp_valid = 1'b1;
         for (int b = 0; b < 4; b++) begin
            settle(); tick();
         end
         mem_resp_valid = 1'b0;
      end
      ic_req_valid = 1'b0; dc_req_valid = 1'b0; mem_req_ready = 1'b0;
      settle(); tick();

      // reset during the second read beat, then stray beats after release
      ic_req_valid = 1'b1;
      settle(); tick();
      mem_req_ready = 1'b1;
      settle(); tick();
      ic_req_valid = 1'b0; mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 128'h55;
      settle();
      chk("rr5_beat0", ic_resp_valid, 1'b1);
      tick();
      reset_n = 1'b0;
      #1;
      chk("rst_mid_rv", {ic_resp_valid, dc_resp_valid}, 2'b00);
      chk("rst_mid_owner", arb_owner, 2'b00);
      chk("rst_mid_data", ic_resp_data, 128'h0);
      chk("rst_mid_ctl", obs(), 7'b0);
      #2;
      reset_n = 1'b1;
      tick();
      for (int s = 0; s < 2; s++) begin
         settle();
         chk($sformatf("stray%0d_rv", s), {ic_resp_valid, dc_resp_valid}, 2'b00);
         chk($sformatf("stray%0d_own", s), arb_owner, 2'b00);
         tick();
      end
      mem_resp_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
